// File: rtl/dac8563_pkg.sv
// Shared types and constants for the DAC8563 command sequencer.
// Define DAC8563_INTREF_EN to add the internal-reference word to the init sequence.
package dac8563_pkg;

  typedef enum logic [3:0] {
    StRstWait   = 4'd0,
    StInitIssue = 4'd1,
    StIdle      = 4'd2,
    StIssue     = 4'd3,
    StWaitBusy  = 4'd4,
    StWaitDone  = 4'd5
  } state_e;

  localparam logic [2:0] SPI_IDLE = 3'd0;
  localparam logic [2:0] SPI_DONE = 3'd4;

  localparam logic [2:0] CMD_WR_UPD = 3'b011;
  localparam logic [2:0] ADDR_A     = 3'b000;
  localparam logic [2:0] ADDR_B     = 3'b001;

  localparam logic [23:0] INIT_SW_RST = 24'h28_0001;
  localparam logic [23:0] INIT_PWR_UP = 24'h20_0003;
  localparam logic [23:0] INIT_LDAC   = 24'h30_0003;

`ifdef DAC8563_INTREF_EN
  localparam logic [23:0] INIT_INT_REF = 24'h38_0001;
  localparam int unsigned NUM_INIT     = 4;
`else
  localparam int unsigned NUM_INIT     = 3;
`endif

  function automatic logic [23:0] build_word(input logic [2:0] cmd, input logic [2:0] addr,
                                             input logic [15:0] data);
    return {2'b00, cmd, addr, data};
  endfunction

  function automatic logic [23:0] init_word(input logic [1:0] idx);
    logic [23:0] w;
`ifdef DAC8563_INTREF_EN
    case (idx)
      2'd0:    w = INIT_SW_RST;
      2'd1:    w = INIT_PWR_UP;
      2'd2:    w = INIT_INT_REF;
      default: w = INIT_LDAC;
    endcase
`else
    case (idx)
      2'd0:    w = INIT_SW_RST;
      2'd1:    w = INIT_PWR_UP;
      default: w = INIT_LDAC;
    endcase
`endif
    return w;
  endfunction

endpackage

// File: rtl/dac8563_rr_arb.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the pointer,
// and the pointer moves to the other channel whenever a grant is taken.
module dac8563_rr_arb (
  input  logic i_clk,
  input  logic i_fRST,
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_take,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic ptr_b_q;

  always_comb begin
    o_gnt_a = i_a_req & (~i_b_req | ~ptr_b_q);
    o_gnt_b = i_b_req & (~i_a_req | ptr_b_q);
  end

  always_ff @(posedge i_clk or posedge i_fRST) begin
    if (i_fRST) begin
      ptr_b_q <= 1'b0;
    end else if (i_take) begin
      ptr_b_q <= o_gnt_a;
    end
  end

endmodule

// File: rtl/dac8563_ctrl.sv
// DAC8563 command sequencer: plays the init words, then arbitrates channel A/B updates
// into the SPI master. DAC8563_INTREF_EN selects the 4-word init sequence.
module dac8563_ctrl
  import dac8563_pkg::*;
#(
  parameter int unsigned PWRUP_DLY = 200,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        i_clk,
  input  logic        i_fRST,
  input  logic        i_a_req,
  input  logic [15:0] i_a_data,
  input  logic        i_b_req,
  input  logic [15:0] i_b_data,
  output logic        o_a_ack,
  output logic        o_b_ack,
  output logic        o_spi_start,
  output logic [23:0] o_mosi_data,
  input  logic [2:0]  i_spi_state,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err,
  output logic [3:0]  o_state
);

  localparam int unsigned CntMax = (PWRUP_DLY > TIMEOUT) ? PWRUP_DLY : TIMEOUT;
  localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
  localparam logic [1:0]  LastIdx = 2'(NUM_INIT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            init_tag_q, init_tag_d;
  logic [23:0]     mosi_q, mosi_d;
  logic            start_q, start_d;
  logic            a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic            ready_q, ready_d, busy_q, busy_d, err_q, err_d;
  logic            gnt_a, gnt_b, arb_take;

  dac8563_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_fRST  (i_fRST),
    .i_a_req (i_a_req),
    .i_b_req (i_b_req),
    .i_take  (arb_take),
    .o_gnt_a (gnt_a),
    .o_gnt_b (gnt_b)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    init_tag_d = init_tag_q;
    mosi_d     = mosi_q;
    start_d    = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    ready_d    = ready_q;
    err_d      = err_q;
    arb_take   = 1'b0;

    unique case (state_q)
      StRstWait: begin
        if (cnt_q == CntW'(PWRUP_DLY - 1)) begin
          state_d = StInitIssue;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StInitIssue: begin
        mosi_d     = init_word(idx_q);
        init_tag_d = 1'b1;
        state_d    = StIssue;
      end
      StIdle: begin
        if (gnt_a || gnt_b) begin
          arb_take   = 1'b1;
          mosi_d     = gnt_a ? build_word(CMD_WR_UPD, ADDR_A, i_a_data)
                             : build_word(CMD_WR_UPD, ADDR_B, i_b_data);
          a_ack_d    = gnt_a;
          b_ack_d    = gnt_b;
          init_tag_d = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (i_spi_state == SPI_IDLE) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (i_spi_state != SPI_IDLE) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          init_tag_d = 1'b0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (i_spi_state == SPI_DONE) begin
          if (init_tag_q && idx_q != LastIdx) begin
            idx_d   = idx_q + 2'd1;
            state_d = StInitIssue;
          end else begin
            // Last init word done marks the DAC as configured.
            if (init_tag_q) ready_d = 1'b1;
            init_tag_d = 1'b0;
            state_d    = StIdle;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          init_tag_d = 1'b0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRstWait;
    endcase

    busy_d = (state_d == StIssue) || (state_d == StWaitBusy) || (state_d == StWaitDone);
  end

  always_ff @(posedge i_clk or posedge i_fRST) begin
    if (i_fRST) begin
      state_q    <= StRstWait;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      init_tag_q <= 1'b0;
      mosi_q     <= '0;
      start_q    <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      init_tag_q <= init_tag_d;
      mosi_q     <= mosi_d;
      start_q    <= start_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_state     = state_q;
  assign o_mosi_data = mosi_q;
  assign o_spi_start = start_q;
  assign o_a_ack     = a_ack_q;
  assign o_b_ack     = b_ack_q;
  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_dac8563_ctrl.sv
// Self-checking bench for dac8563_ctrl: SPI master model, transaction scoreboard and
// directed scenarios (init, arbitration, timeouts, mid-transaction reset).
module tb_dac8563_ctrl;

  localparam int unsigned PWRUP_DLY = 200;
  localparam int unsigned TIMEOUT   = 4096;
  localparam int MODE_NORMAL = 0, MODE_STUCK_IDLE = 1, MODE_STUCK_RUN = 2;

  logic        i_clk = 1'b0;
  logic        i_fRST;
  logic        i_a_req, i_b_req;
  logic [15:0] i_a_data, i_b_data;
  logic [2:0]  i_spi_state;
  logic        o_a_ack, o_b_ack, o_spi_start, o_ready, o_busy, o_err;
  logic [23:0] o_mosi_data;
  logic [3:0]  o_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          spi_mode = MODE_NORMAL;
  int          n_a_ack = 0, n_b_ack = 0;
  logic [23:0] issued[$];
  logic [23:0] exp_q[$];
  logic [23:0] init_exp[$];

  dac8563_ctrl #(.PWRUP_DLY(PWRUP_DLY), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_fRST      (i_fRST),
    .i_a_req     (i_a_req),
    .i_a_data    (i_a_data),
    .i_b_req     (i_b_req),
    .i_b_data    (i_b_data),
    .o_a_ack     (o_a_ack),
    .o_b_ack     (o_b_ack),
    .o_spi_start (o_spi_start),
    .o_mosi_data (o_mosi_data),
    .i_spi_state (i_spi_state),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_issued(input string name, input int idx, input logic [23:0] exp);
    if (idx < issued.size()) chk(name, {8'h0, issued[idx]}, {8'h0, exp});
    else chk(name, 32'hEE00_0000, {8'h0, exp});
  endtask

  // SPI master model: done 30 cycles after it sees start, unless forced stuck.
  initial begin : spi_model
    int t;
    t = 0;
    i_spi_state = 3'd0;
    forever begin
      step();
      if (i_fRST) begin
        t = 0;
        i_spi_state = 3'd0;
      end else if (spi_mode == MODE_STUCK_IDLE) begin
        i_spi_state = 3'd0;
      end else if (spi_mode == MODE_STUCK_RUN) begin
        if (o_spi_start) i_spi_state = 3'd2;
      end else if (t != 0) begin
        t++;
        i_spi_state = (t < 3) ? 3'd1 : (t < 28) ? 3'd2 : (t < 30) ? 3'd3 : (t == 30) ? 3'd4 : 3'd0;
        if (t > 30) t = 0;
      end else if (o_spi_start) begin
        t = 1;
        i_spi_state = 3'd1;
      end else begin
        i_spi_state = 3'd0;
      end
    end
  end

  // Scoreboard: expected word stream, round-robin choice and ready, checked every cycle.
  initial begin : compare
    logic        pa, pb, pstart, prst, perr, pdone, in_xfer, cur_init, ptr_b_m, ready_m;
    logic        exp_a, exp_b;
    logic [2:0]  pspi;
    logic [15:0] pad, pbd;
    logic [23:0] w;
    int          n_started, n_init_done;
`ifdef DAC8563_INTREF_EN
    init_exp = '{24'h280001, 24'h200003, 24'h380001, 24'h300003};
`else
    init_exp = '{24'h280001, 24'h200003, 24'h300003};
`endif
    {pa, pb, pstart, prst, perr, pdone, in_xfer, cur_init, ptr_b_m, ready_m} = '0;
    pspi = 3'd0; pad = '0; pbd = '0;
    n_started = 0; n_init_done = 0;
    forever begin
      @(negedge i_clk);
      if (i_fRST) begin
        chk("reset_outputs", {o_spi_start, o_a_ack, o_b_ack, o_ready, o_busy, o_err, o_state,
                              o_mosi_data}, 32'h0);
        exp_q.delete();
        {in_xfer, cur_init, ptr_b_m, ready_m} = '0;
        n_started = 0; n_init_done = 0;
      end else begin
        if (prst) foreach (init_exp[i]) exp_q.push_back(init_exp[i]);
        chk("ready", o_ready, ready_m);
        if (perr) chk("err_sticky", o_err, 1);
        if (pstart) chk("start_one_cycle", o_spi_start, 0);
        if (pdone) chk("busy_after_done", o_busy, 0);
        if (o_a_ack || o_b_ack) begin
          exp_a = pa && (!pb || !ptr_b_m);
          exp_b = pb && (!pa || ptr_b_m);
          chk("ack_grant", {o_a_ack, o_b_ack}, {exp_a, exp_b});
          chk("ack_after_init", ready_m, 1);
          w = o_a_ack ? (24'h180000 | {8'h0, pad}) : (24'h190000 | {8'h0, pbd});
          chk("ack_word", o_mosi_data, w);
          chk("ack_busy", o_busy, 1);
          exp_q.push_back(w);
          ptr_b_m = o_a_ack;
          in_xfer = 1'b0;
          if (o_a_ack) n_a_ack++;
          if (o_b_ack) n_b_ack++;
        end
        if (o_spi_start) begin
          chk("start_master_idle", pspi, 0);
          chk("start_busy", o_busy, 1);
          if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
          else begin
            w = exp_q.pop_front();
            chk("start_word", o_mosi_data, w);
          end
          issued.push_back(o_mosi_data);
          cur_init = (n_started < init_exp.size());
          n_started++;
          in_xfer = 1'b1;
        end
      end
      pdone = !i_fRST && in_xfer && (i_spi_state == 3'd4);
      if (pdone) begin
        in_xfer = 1'b0;
        if (cur_init) begin
          n_init_done++;
          if (n_init_done == init_exp.size()) ready_m = 1'b1;
        end
      end
      pa = i_a_req; pb = i_b_req; pad = i_a_data; pbd = i_b_data;
      pstart = o_spi_start; prst = i_fRST; perr = o_err; pspi = i_spi_state;
    end
  end

  task automatic wait_ack(input bit ch_b);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (ch_b ? o_b_ack : o_a_ack) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(ch_b ? "ack_b_bound" : "ack_a_bound", 0, 1);
  endtask

  task automatic serve(input bit ch_b, input logic [15:0] d);
    if (ch_b) begin i_b_data = d; i_b_req = 1'b1; end
    else begin i_a_data = d; i_a_req = 1'b1; end
    wait_ack(ch_b);
    if (ch_b) i_b_req = 1'b0;
    else i_a_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!o_busy && i_spi_state == 3'd0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_bound", 0, 1);
  endtask

  task automatic wait_spi_run();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i_spi_state == 3'd2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("spi_run_bound", 0, 1);
  endtask

  // Release reset, then check first-word latency and the replayed init sequence.
  task automatic release_and_init(input string tag);
    int n, base;
    bit ok;
    base = issued.size();
    i_fRST = 1'b0;
    n = 0;
    for (int i = 0; i < PWRUP_DLY + 20; i++) begin
      step();
      n++;
      if (o_spi_start) break;
    end
    chk({tag, "_first_start_cycle"}, n, PWRUP_DLY + 2);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (o_ready) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_ready"}, ok, 1);
    chk({tag, "_init_count"}, issued.size() - base, init_exp.size());
    chk_issued({tag, "_init0"}, base, 24'h280001);
    chk_issued({tag, "_init1"}, base + 1, 24'h200003);
    chk_issued({tag, "_init_last"}, base + init_exp.size() - 1, 24'h300003);
  endtask

  initial begin : main
    int base, na, n;
    i_fRST = 1'b1;
    i_a_req = 1'b0; i_b_req = 1'b0; i_a_data = '0; i_b_data = '0;
    repeat (3) step();
    chk("rst_state", o_state, 4'd0);
    chk("rst_mosi", o_mosi_data, 24'h0);
    chk("rst_flags", {o_ready, o_busy, o_err, o_spi_start}, 4'b0);

    // B requested before init finishes stays pending until ready.
    i_b_data = 16'h5555;
    i_b_req = 1'b1;
    release_and_init("init");
`ifdef DAC8563_INTREF_EN
    chk_issued("init_intref", 2, 24'h380001);
`endif
    wait_ack(1);
    i_b_req = 1'b0;
    chk("pending_b_ready", o_ready, 1);
    wait_idle();
    chk_issued("pending_b_word", init_exp.size(), 24'h195555);

    // Simultaneous A and B with pointer at A.
    base = issued.size();
    fork
      serve(0, 16'h1234);
      serve(1, 16'hABCD);
    join
    wait_idle();
    chk_issued("rr_first_a", base, 24'h181234);
    chk_issued("rr_then_b", base + 1, 24'h19ABCD);

    // Single A: one word, one start.
    base = issued.size();
    serve(0, 16'h8000);
    wait_idle();
    repeat (5) step();
    chk("single_a_starts", issued.size() - base, 1);
    chk_issued("single_a_word", base, 24'h188000);

    // Repeated double request now favours B.
    base = issued.size();
    fork
      serve(0, 16'h0101);
      serve(1, 16'h0202);
    join
    wait_idle();
    chk_issued("rr2_first_b", base, 24'h190202);
    chk_issued("rr2_then_a", base + 1, 24'h180101);

    // A raised and dropped while busy is never served.
    base = issued.size();
    na = n_a_ack;
    serve(1, 16'h3333);
    wait_spi_run();
    i_a_data = 16'h7777;
    i_a_req = 1'b1;
    repeat (3) step();
    i_a_req = 1'b0;
    wait_idle();
    repeat (5) step();
    chk("dropped_a_no_ack", n_a_ack - na, 0);
    chk("dropped_a_one_word", issued.size() - base, 1);
    chk_issued("dropped_b_word", base, 24'h193333);

    // WAIT_BUSY timeout: master never leaves idle.
    spi_mode = MODE_STUCK_IDLE;
    serve(0, 16'h0001);
    step();
    chk("to1_start", o_spi_start, 1);
    n = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      step();
      n++;
      if (o_err) break;
    end
    chk("to1_cycles", n, TIMEOUT);
    chk("to1_state_idle", o_state, 4'd2);
    chk("to1_outputs", {o_busy, o_spi_start, o_ready}, 3'b001);

    // WAIT_DONE timeout: master stuck in run.
    spi_mode = MODE_STUCK_RUN;
    serve(1, 16'h2222);
    step();
    chk("to2_start", o_spi_start, 1);
    n = 0;
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      step();
      n++;
      if (!o_busy) break;
    end
    chk("to2_cycles", n, TIMEOUT + 1);
    chk("to2_state_idle", o_state, 4'd2);
    chk("to2_flags", {o_err, o_ready, o_spi_start}, 3'b110);
    spi_mode = MODE_NORMAL;
    repeat (3) step();

    // Reset while waiting for done: outputs clear at once, init replays.
    serve(1, 16'h0F0F);
    wait_spi_run();
    i_fRST = 1'b1;
    #1;
    chk("midrst_state", o_state, 4'd0);
    chk("midrst_outputs", {o_busy, o_err, o_ready, o_spi_start, o_a_ack, o_b_ack}, 6'b0);
    chk("midrst_mosi", o_mosi_data, 24'h0);
    repeat (3) step();
    release_and_init("replay");
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
